// File: rtl/sobel_window_sequencer.sv
// Snapshots a WIN-row line buffer and emits WIN x WIN pixel windows.
// Ports: clk, n_rst, in_buffer/start/sweep/start_col/edge_mode/abort in;
//        window/win_valid/win_col/win_last/busy/cfg_err out (handshake via out_ready).
module sobel_window_sequencer #(
    parameter int PIX_W      = 8,
    parameter int ROW_PIXELS = 8,
    parameter int WIN        = 3,
    parameter int COL_W      = $clog2(ROW_PIXELS)
) (
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic [WIN-1:0][ROW_PIXELS-1:0][PIX_W-1:0] in_buffer,
    input  logic                                     start,
    input  logic                                     sweep,
    input  logic [COL_W-1:0]                         start_col,
    input  logic [1:0]                               edge_mode,
    input  logic                                     abort,
    input  logic                                     out_ready,
    output logic [WIN-1:0][WIN-1:0][PIX_W-1:0]        window,
    output logic                                     win_valid,
    output logic [COL_W-1:0]                         win_col,
    output logic                                     win_last,
    output logic                                     busy,
    output logic                                     cfg_err
);

    localparam int H  = (WIN - 1) / 2;
    localparam int IW = $clog2(ROW_PIXELS);
    localparam logic [COL_W:0]   ROW_LIM = (COL_W + 1)'(ROW_PIXELS);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(ROW_PIXELS - 1);

    typedef logic [ROW_PIXELS-1:0][PIX_W-1:0] row_t;
    typedef enum logic {IDLE, EMIT} state_t;

    state_t                state;
    state_t                state_n;
    row_t [WIN-1:0]        snap;
    logic [COL_W-1:0]      col;
    logic [1:0]            mode;
    logic                  sweep_q;
    logic                  err_q;
    logic                  last;
    logic                  accept;
    logic                  xfer;

    assign accept = (state == IDLE) && start;
    assign last   = !sweep_q || (col == '0);
    // Abort outranks a simultaneous transfer.
    assign xfer   = (state == EMIT) && !abort && out_ready;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = EMIT;
            EMIT: if (abort || (out_ready && last)) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            snap    <= '0;
            col     <= '0;
            mode    <= '0;
            sweep_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= 1'b0;
            if (accept) begin
                snap    <= in_buffer;
                mode    <= edge_mode;
                sweep_q <= sweep;
                if ({1'b0, start_col} >= ROW_LIM) begin
                    col   <= COL_MAX;
                    err_q <= 1'b1;
                end else begin
                    col <= start_col;
                end
            end else if (xfer && !last) begin
                col <= col - 1'b1;
            end
        end
    end

    // Resolve one tap: idx may fall up to H outside the row on either side.
    function automatic logic [PIX_W-1:0] pick(
        input row_t       row,
        input int         idx,
        input logic [1:0] m
    );
        int           k;
        logic         zero;
        logic [IW-1:0] sel;
        k    = idx;
        zero = 1'b0;
        unique case (m)
            2'd1: begin
                if (k < 0) k = 0;
                else if (k > ROW_PIXELS - 1) k = ROW_PIXELS - 1;
            end
            2'd2: begin
                if (k < 0 || k > ROW_PIXELS - 1) begin
                    zero = 1'b1;
                    k    = 0;
                end
            end
            default: begin
                if (k < 0) k = k + ROW_PIXELS;
                else if (k > ROW_PIXELS - 1) k = k - ROW_PIXELS;
            end
        endcase
        sel = IW'(k);
        return zero ? '0 : row[sel];
    endfunction

    always_comb begin
        window = '0;
        if (state == EMIT) begin
            for (int r = 0; r < WIN; r++) begin
                for (int j = 0; j < WIN; j++) begin
                    window[r][j] = pick(snap[r], int'(col) + j - H, mode);
                end
            end
        end
    end

    assign win_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    assign win_col   = win_valid ? col : '0;
    assign win_last  = win_valid && last;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Testbench for sobel_window_sequencer: random and directed requests
// checked every cycle against an array-based window model.
module tb_sobel_window_sequencer;

    localparam int PIX_W = 8;
    localparam int RP    = 8;
    localparam int WIN   = 3;
    localparam int COL_W = 4;
    localparam int H     = 1;

    logic                                 clk = 1'b0;
    logic                                 n_rst;
    logic [WIN-1:0][RP-1:0][PIX_W-1:0]    in_buffer;
    logic                                 start;
    logic                                 sweep;
    logic [COL_W-1:0]                     start_col;
    logic [1:0]                           edge_mode;
    logic                                 abort;
    logic                                 out_ready;
    logic [WIN-1:0][WIN-1:0][PIX_W-1:0]   window;
    logic                                 win_valid;
    logic [COL_W-1:0]                     win_col;
    logic                                 win_last;
    logic                                 busy;
    logic                                 cfg_err;

    int checks = 0;
    int errors = 0;

    int m_active = 0;
    int m_col    = 0;
    int m_mode   = 0;
    int m_sweep  = 0;
    int m_err    = 0;
    int m_xfers  = 0;
    int m_snap[WIN][RP];

    sobel_window_sequencer #(
        .PIX_W(PIX_W), .ROW_PIXELS(RP), .WIN(WIN), .COL_W(COL_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .in_buffer(in_buffer), .start(start),
        .sweep(sweep), .start_col(start_col), .edge_mode(edge_mode),
        .abort(abort), .out_ready(out_ready), .window(window),
        .win_valid(win_valid), .win_col(win_col), .win_last(win_last),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_pix(int r, int j);
        int idx;
        idx = m_col + j - H;
        if (m_mode == 1) begin
            if (idx < 0) idx = 0;
            if (idx > RP - 1) idx = RP - 1;
        end else if (m_mode == 2) begin
            if (idx < 0 || idx > RP - 1) return 0;
        end else begin
            idx = ((idx % RP) + RP) % RP;
        end
        return m_snap[r][idx];
    endfunction

    // Reference model: request-level bookkeeping at each clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                m_active = 0;
                m_col    = 0;
                m_mode   = 0;
                m_sweep  = 0;
                m_err    = 0;
            end else begin
                m_err = 0;
                if (m_active == 0) begin
                    if (start) begin
                        for (int r = 0; r < WIN; r++)
                            for (int c = 0; c < RP; c++)
                                m_snap[r][c] = int'(in_buffer[r][c]);
                        m_err    = (int'(start_col) > RP - 1) ? 1 : 0;
                        m_col    = m_err ? RP - 1 : int'(start_col);
                        m_mode   = int'(edge_mode);
                        m_sweep  = int'(sweep);
                        m_active = 1;
                        m_xfers  = 0;
                    end
                end else if (abort) begin
                    m_active = 0;
                end else if (out_ready) begin
                    m_xfers++;
                    if (m_sweep == 0 || m_col == 0) m_active = 0;
                    else m_col--;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst) begin
                chk("valid", int'(win_valid), m_active);
                chk("busy", int'(busy), m_active);
                chk("cfg_err", int'(cfg_err), m_err);
                if (m_active != 0) begin
                    chk("col", int'(win_col), m_col);
                    chk("last", int'(win_last),
                        (m_sweep == 0 || m_col == 0) ? 1 : 0);
                    for (int r = 0; r < WIN; r++)
                        for (int j = 0; j < WIN; j++)
                            chk("pix", int'(window[r][j]), ref_pix(r, j));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < RP; c++)
                in_buffer[r][c] = PIX_W'(r * 16 + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < RP; c++)
                in_buffer[r][c] = PIX_W'($urandom);
    endtask

    task automatic req(input int col, input int sw, input int md);
        start     = 1'b1;
        start_col = COL_W'(col);
        sweep     = sw[0];
        edge_mode = 2'(md);
    endtask

    int exp_w[3][3];
    int n;
    int held;

    initial begin
        exp_w[0] = '{7, 0, 1};
        exp_w[1] = '{0, 0, 1};
        exp_w[2] = '{0, 0, 1};
        n_rst = 1'b0;
        start = 1'b0;
        sweep = 1'b0;
        start_col = '0;
        edge_mode = '0;
        abort = 1'b0;
        out_ready = 1'b0;
        fill_pattern();
        tick();
        chk("rst_valid", int'(win_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_win", int'(window != '0), 0);
        chk("rst_col", int'(win_col), 0);
        chk("rst_last", int'(win_last), 0);
        chk("rst_err", int'(cfg_err), 0);
        n_rst = 1'b1;
        tick();

        // single window, wrap, col 6
        req(6, 0, 0);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_valid", int'(win_valid), 1);
        chk("t1_last", int'(win_last), 1);
        chk("t1_col", int'(win_col), 6);
        for (int r = 0; r < WIN; r++) begin
            chk("t1_j2", int'(window[r][2]), r * 16 + 7);
            chk("t1_j1", int'(window[r][1]), r * 16 + 6);
            chk("t1_j0", int'(window[r][0]), r * 16 + 5);
        end
        tick();
        chk("t1_idle", int'(win_valid), 0);

        // edge modes at col 0
        for (int md = 0; md < 3; md++) begin
            out_ready = 1'b0;
            req(0, 0, md);
            tick();
            start = 1'b0;
            for (int j = 0; j < WIN; j++)
                chk("t2_row0", int'(window[0][j]), exp_w[md][j]);
            if (md == 2) begin
                chk("t2_z_j2", int'(window[2][2]), 8'h21);
                chk("t2_z_j1", int'(window[2][1]), 8'h20);
                chk("t2_z_j0", int'(window[2][0]), 8'h00);
            end
            out_ready = 1'b1;
            tick();
        end

        // sweep from 7 with backpressure and a changing line buffer
        req(7, 1, 0);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        held = 0;
        n = 0;
        while (m_active != 0 && n < 100) begin
            n++;
            if (m_col == 4 && held == 0) begin
                held = 1;
                out_ready = 1'b0;
                repeat (3) begin
                    tick();
                    chk("t3_hold", int'(win_col), 4);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            fill_random();
            tick();
        end
        chk("t3_done", m_active, 0);
        chk("t3_xfers", m_xfers, 8);
        fill_pattern();
        out_ready = 1'b1;
        tick();

        // out-of-range column, start while busy
        out_ready = 1'b0;
        req(9, 0, 0);
        tick();
        chk("t4_err", int'(cfg_err), 1);
        chk("t4_col", int'(win_col), 7);
        req(2, 1, 1);
        tick();
        chk("t4_err_pulse", int'(cfg_err), 0);
        chk("t4_ignored", int'(win_col), 7);
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_idle", int'(busy), 0);

        // abort at col 5, start beats abort, then reset mid-sweep
        req(7, 1, 0);
        tick();
        start = 1'b0;
        n = 0;
        while (m_col != 5 && n < 10) begin
            n++;
            tick();
        end
        chk("t5_reach5", int'(win_col), 5);
        abort = 1'b1;
        tick();
        chk("t5_ab_valid", int'(win_valid), 0);
        chk("t5_ab_busy", int'(busy), 0);
        req(7, 1, 2);
        tick();
        chk("t5_start_wins", int'(win_valid), 1);
        abort = 1'b0;
        start = 1'b0;
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        chk("t5_rst_valid", int'(win_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_win", int'(window != '0), 0);
        chk("t5_rst_col", int'(win_col), 0);
        chk("t5_rst_last", int'(win_last), 0);
        tick();
        n_rst = 1'b1;
        tick();

        // back-to-back requests
        req(3, 0, 1);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_first", int'(win_col), 3);
        tick();
        chk("t6_gap", int'(win_valid), 0);
        req(2, 0, 0);
        tick();
        start = 1'b0;
        chk("t6_second", int'(win_valid), 1);
        chk("t6_col", int'(win_col), 2);
        tick();

        // random requests
        for (int t = 0; t < 25; t++) begin
            fill_random();
            req($urandom_range(0, 11), $urandom_range(0, 1),
                $urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            start = 1'b0;
            n = 0;
            while (m_active != 0 && n < 200) begin
                n++;
                fill_random();
                out_ready = ($urandom_range(0, 3) != 0);
                abort = ($urandom_range(0, 19) == 0);
                tick();
            end
            abort = 1'b0;
            chk("rand_done", m_active, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
